// File: rtl/id_ex_stage.sv
// ID/EX pipeline register built as a 2-entry skid buffer with immediate decode and x0 forcing.
// Optional write-back bypass into the captured operands is compiled in with ID_EX_WB_BYPASS_EN.
module id_ex_stage #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     i,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            in_valid,
   output logic            in_ready,
   output logic            out_valid,
   input  logic            out_ready,
   input  logic            flush,
   input  logic            wb_write,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1,
   output logic [XLEN-1:0] ex_rs2,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rd,
   output logic [6:0]      ex_opcode,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7b5,
   output logic            ex_illegal
);

   // state | meaning
   // EMPTY | no entry held
   // ONE   | slot0 holds the only entry
   // FULL  | slot0 oldest, slot1 newest; upstream stalled
   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
      logic [XLEN-1:0] imm;
      logic [4:0]      rd;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic            funct7b5;
      logic            illegal;
   } entry_t;

   state_t          state, state_nxt;
   entry_t          slot0, slot1, entry_new;
   logic            in_xfer, out_xfer;
   logic            load0, load1, shift;
   logic [XLEN-1:0] imm_dec;
   logic            legal_op;
   logic [XLEN-1:0] rs1_src, rs2_src;

   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;
   assign out_valid = (state != EMPTY);

   always_comb begin
      imm_dec  = '0;
      legal_op = 1'b0;
      case (i[6:0])
         7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
            imm_dec  = {{(XLEN-12){i[31]}}, i[31:20]};
            legal_op = 1'b1;
         end
         7'b0100011: begin
            imm_dec  = {{(XLEN-12){i[31]}}, i[31:25], i[11:7]};
            legal_op = 1'b1;
         end
         7'b1100011: begin
            imm_dec  = {{(XLEN-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            legal_op = 1'b1;
         end
         7'b0110111, 7'b0010111: begin
            imm_dec  = {{(XLEN-32){i[31]}}, i[31:12], 12'b0};
            legal_op = 1'b1;
         end
         7'b1101111: begin
            imm_dec  = {{(XLEN-21){i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            legal_op = 1'b1;
         end
         7'b0110011, 7'b0111011, 7'b0001111, 7'b1110011: legal_op = 1'b1;
         default: ;
      endcase
   end

`ifdef ID_EX_WB_BYPASS_EN
   // A same-cycle write-back to the addressed register wins over the stale file read.
   assign rs1_src = (wb_write && wb_rd != 5'd0 && wb_rd == i[19:15]) ? wb_data : rs1_data;
   assign rs2_src = (wb_write && wb_rd != 5'd0 && wb_rd == i[24:20]) ? wb_data : rs2_data;
`else
   logic unused_wb;
   assign unused_wb = ^{wb_write, wb_rd, wb_data};
   assign rs1_src   = rs1_data;
   assign rs2_src   = rs2_data;
`endif

   always_comb begin
      entry_new          = '0;
      entry_new.pc       = pc;
      entry_new.rs1      = (i[19:15] == 5'd0) ? '0 : rs1_src;
      entry_new.rs2      = (i[24:20] == 5'd0) ? '0 : rs2_src;
      entry_new.imm      = imm_dec;
      entry_new.rd       = i[11:7];
      entry_new.opcode   = i[6:0];
      entry_new.funct3   = i[14:12];
      entry_new.funct7b5 = i[30];
      entry_new.illegal  = (i[1:0] != 2'b11) | ~legal_op;
   end

   always_comb begin
      state_nxt = state;
      load0     = 1'b0;
      load1     = 1'b0;
      shift     = 1'b0;
      case (state)
         EMPTY: if (in_xfer) begin
            state_nxt = ONE;
            load0     = 1'b1;
         end
         ONE: begin
            if (in_xfer && !out_xfer) begin
               state_nxt = FULL;
               load1     = 1'b1;
            end else if (!in_xfer && out_xfer) begin
               state_nxt = EMPTY;
            end else if (in_xfer && out_xfer) begin
               load0     = 1'b1;
            end
         end
         FULL: if (out_xfer) begin
            state_nxt = ONE;
            shift     = 1'b1;
         end
         default: state_nxt = EMPTY;
      endcase
      if (flush) begin
         state_nxt = EMPTY;
         load0     = 1'b0;
         load1     = 1'b0;
         shift     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         in_ready <= 1'b1;
         slot0    <= '0;
         slot1    <= '0;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt != FULL);
         if (load0)
            slot0 <= entry_new;
         else if (shift)
            slot0 <= slot1;
         if (load1)
            slot1 <= entry_new;
      end
   end

   assign ex_pc       = slot0.pc;
   assign ex_rs1      = slot0.rs1;
   assign ex_rs2      = slot0.rs2;
   assign ex_imm      = slot0.imm;
   assign ex_rd       = slot0.rd;
   assign ex_opcode   = slot0.opcode;
   assign ex_funct3   = slot0.funct3;
   assign ex_funct7b5 = slot0.funct7b5;
   assign ex_illegal  = slot0.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: handshake, ordering, decode, flush, reset and optional bypass.
module tb_id_ex_stage;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, flush, wb_write;
   logic [31:0] i;
   logic [63:0] pc, rs1_data, rs2_data, wb_data;
   logic [4:0]  wb_rd;
   logic [63:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
   logic [4:0]  ex_rd;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic        ex_funct7b5, ex_illegal;
   int          n_cmp = 0;
   int          n_err = 0;

`ifdef ID_EX_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   id_ex_stage #(.XLEN(64)) dut (
      .clk(clk), .rst(rst), .i(i), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
      .flush(flush), .wb_write(wb_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_rd(ex_rd),
      .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
      .ex_illegal(ex_illegal)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      wb_write = 1'b0; wb_rd = 5'd0; wb_data = 64'd0;
      i = 32'd0; pc = 64'd0; rs1_data = 64'd0; rs2_data = 64'd0;
      cyc(); cyc();
      rst = 1'b0;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_ex_pc", ex_pc, 64'd0);
      chk("rst_ex_imm", ex_imm, 64'd0);

      // addi x1,x0,10 with a nonzero rs1 read that must be forced to zero
      i = 32'h00A00093; pc = 64'h100; rs1_data = 64'hDEAD; in_valid = 1'b1; out_ready = 1'b1;
      cyc();
      in_valid = 1'b0;
      chk("addi_out_valid", out_valid, 1'b1);
      chk("addi_imm", ex_imm, 64'd10);
      chk("addi_rd", ex_rd, 5'd1);
      chk("addi_rs1_x0", ex_rs1, 64'd0);
      chk("addi_pc", ex_pc, 64'h100);
      chk("addi_opcode", ex_opcode, 7'h13);
      chk("addi_illegal", ex_illegal, 1'b0);
      cyc();
      chk("addi_drained", out_valid, 1'b0);

      // stall: three offered, two accepted, order preserved
      out_ready = 1'b0; in_valid = 1'b1;
      i = 32'h00100113; pc = 64'h200;
      cyc();
      chk("stall_ready_a", in_ready, 1'b1);
      i = 32'h00200193; pc = 64'h204;
      cyc();
      chk("stall_ready_b", in_ready, 1'b0);
      chk("stall_head_b", ex_pc, 64'h200);
      i = 32'h00300213; pc = 64'h208;
      cyc();
      chk("stall_head_c", ex_pc, 64'h200);
      chk("stall_rd_c", ex_rd, 5'd2);
      chk("stall_ready_c", in_ready, 1'b0);
      in_valid = 1'b0; out_ready = 1'b1;
      cyc();
      chk("pop1_pc", ex_pc, 64'h204);
      chk("pop1_rd", ex_rd, 5'd3);
      chk("pop1_ready", in_ready, 1'b1);
      cyc();
      chk("pop2_empty", out_valid, 1'b0);

      // immediate decode, refilling slot0 on simultaneous in/out
      out_ready = 1'b0; in_valid = 1'b1; i = 32'hFE000EE3; pc = 64'h300;
      cyc();
      chk("btype_imm", ex_imm, 64'hFFFFFFFFFFFFFFFC);
      chk("btype_illegal", ex_illegal, 1'b0);
      out_ready = 1'b1; i = 32'h0000006F;
      cyc();
      chk("jtype_imm", ex_imm, 64'd0);
      chk("jtype_opcode", ex_opcode, 7'h6F);
      i = 32'h800002B7;
      cyc();
      chk("utype_imm", ex_imm, 64'hFFFFFFFF80000000);
      chk("utype_rd", ex_rd, 5'd5);
      i = 32'h00000000;
      cyc();
      chk("zero_illegal", ex_illegal, 1'b1);
      chk("zero_imm", ex_imm, 64'd0);
      in_valid = 1'b0;
      cyc();
      chk("decode_drained", out_valid, 1'b0);

      // add x3,x1,x2 with a write-back to x1 in the capture cycle
      out_ready = 1'b1; in_valid = 1'b1; i = 32'h002081B3; pc = 64'h400;
      rs1_data = 64'd5; rs2_data = 64'd9; wb_write = 1'b1; wb_rd = 5'd1; wb_data = 64'd7;
      cyc();
      chk("byp_rs1", ex_rs1, BYP ? 64'd7 : 64'd5);
      chk("byp_rs2_untouched", ex_rs2, 64'd9);
      chk("byp_funct7b5", ex_funct7b5, 1'b0);
      wb_rd = 5'd2; i = 32'h402081B3;
      cyc();
      chk("byp_rs2", ex_rs2, BYP ? 64'd7 : 64'd9);
      chk("byp_rs1_untouched", ex_rs1, 64'd5);
      chk("sub_funct7b5", ex_funct7b5, 1'b1);
      wb_rd = 5'd0; i = 32'h002081B3;
      cyc();
      chk("byp_x0_never", ex_rs1, 64'd5);
      in_valid = 1'b0; wb_write = 1'b0;
      cyc();

      // flush while FULL with a new instruction offered
      out_ready = 1'b0; in_valid = 1'b1; i = 32'h00100113; pc = 64'h500;
      cyc();
      pc = 64'h504;
      cyc();
      chk("flush_pre_full", in_ready, 1'b0);
      flush = 1'b1; pc = 64'h508;
      cyc();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", out_valid, 1'b0);
      chk("flush_in_ready", in_ready, 1'b1);
      cyc();
      chk("flush_nothing_kept", out_valid, 1'b0);

      // reset while FULL overrides a ready sink and a pending input
      in_valid = 1'b1; i = 32'hFE000EE3; pc = 64'h600;
      cyc();
      pc = 64'h604;
      cyc();
      chk("rstf_pre_full", in_ready, 1'b0);
      rst = 1'b1; out_ready = 1'b1;
      cyc();
      rst = 1'b0; in_valid = 1'b0;
      chk("rstf_out_valid", out_valid, 1'b0);
      chk("rstf_in_ready", in_ready, 1'b1);
      chk("rstf_ex_pc", ex_pc, 64'd0);
      chk("rstf_ex_imm", ex_imm, 64'd0);
      chk("rstf_ex_rd", ex_rd, 5'd0);
      chk("rstf_ex_opcode", ex_opcode, 7'd0);
      cyc();
      chk("rstf_stays_empty", out_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
